// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-side inputs and hazard/forward outputs of the scoreboard
interface hazard_scoreboard_if;
  logic [4:0]  Rs_D;
  logic [4:0]  Rt_D;
  logic        UsesRs_D;
  logic        UsesRt_D;
  logic [4:0]  DestReg_D;
  logic        RegWrite_D;
  logic        MemRead_D;
  logic        Redirect_E;
  logic        Stall_F;
  logic        Stall_D;
  logic        Flush_D;
  logic        Flush_E;
  logic [1:0]  ForwardA_E;
  logic [1:0]  ForwardB_E;
  logic [15:0] StallCount;
  logic [15:0] FlushCount;
  modport master (
    output Rs_D, Rt_D, UsesRs_D, UsesRt_D, DestReg_D, RegWrite_D, MemRead_D, Redirect_E,
    input  Stall_F, Stall_D, Flush_D, Flush_E, ForwardA_E, ForwardB_E, StallCount, FlushCount
  );
  modport slave (
    input  Rs_D, Rt_D, UsesRs_D, UsesRt_D, DestReg_D, RegWrite_D, MemRead_D, Redirect_E,
    output Stall_F, Stall_D, Flush_D, Flush_E, ForwardA_E, ForwardB_E, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: E/M/W scoreboard giving load-use stalls, redirect flushes and ALU forwarding
module hazard_scoreboard (
  input logic clk,
  input logic reset,
  hazard_scoreboard_if.slave bus
);
  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mr;
    logic [4:0] d;
    logic [4:0] rs;
    logic [4:0] rt;
  } ent_t;
  ent_t        e_q, m_q, w_q, e_d;
  logic [15:0] sc_q, sc_d, fc_q, fc_d;
  logic        lu, stall;
  function automatic logic [1:0] fwd(input ent_t m, input ent_t w, input logic [4:0] src);
    return (m.v & m.rw & ~m.mr & (m.d != 5'd0) & (m.d == src)) ? 2'b10 :
           (w.v & w.rw & (w.d != 5'd0) & (w.d == src)) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    lu = e_q.v & e_q.mr & (e_q.d != 5'd0) &
         ((bus.UsesRs_D & (bus.Rs_D == e_q.d)) | (bus.UsesRt_D & (bus.Rt_D == e_q.d)));
    stall = lu & ~bus.Redirect_E;
    bus.Stall_F = stall;
    bus.Stall_D = stall;
    bus.Flush_D = bus.Redirect_E;
    bus.Flush_E = bus.Redirect_E | stall;
    bus.ForwardA_E = fwd(m_q, w_q, e_q.rs);
    bus.ForwardB_E = fwd(m_q, w_q, e_q.rt);
    bus.StallCount = sc_q;
    bus.FlushCount = fc_q;
    // unused sources are stored as $0 so they can never match a live destination
    e_d = bus.Flush_E ? '0 : {1'b1, bus.RegWrite_D, bus.MemRead_D, bus.DestReg_D,
                              bus.UsesRs_D ? bus.Rs_D : 5'd0, bus.UsesRt_D ? bus.Rt_D : 5'd0};
    sc_d = (stall && sc_q != 16'hFFFF) ? sc_q + 16'd1 : sc_q;
    fc_d = (bus.Redirect_E && fc_q != 16'hFFFF) ? fc_q + 16'd1 : fc_q;
  end
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      e_q  <= '0;
      m_q  <= '0;
      w_q  <= '0;
      sc_q <= '0;
      fc_q <= '0;
    end else begin
      e_q  <= e_d;
      m_q  <= e_q;
      w_q  <= m_q;
      sc_q <= sc_d;
      fc_q <= fc_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed MIPS hazard scenarios checked against an instruction-level pipeline model
`timescale 1ns/1ps
module tb_hazard_scoreboard;
  logic clk, reset;
  int tests, fails;
  hazard_scoreboard_if bus();
  hazard_scoreboard dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    bit v, rw, mr;
    int d, rs, rt;
  } ins_t;
  ins_t p[3];
  int mstall, mflush;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit m_lu();
    return p[0].v && p[0].mr && p[0].d != 0 &&
           ((bus.UsesRs_D && int'(bus.Rs_D) == p[0].d) || (bus.UsesRt_D && int'(bus.Rt_D) == p[0].d));
  endfunction
  function automatic int m_fwd(input int src);
    if (p[1].v && p[1].rw && !p[1].mr && p[1].d != 0 && p[1].d == src) return 2;
    if (p[2].v && p[2].rw && p[2].d != 0 && p[2].d == src) return 1;
    return 0;
  endfunction
  // instruction-level model: each negedge moves instructions one stage down the pipe
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) p[i] <= '{default: 0};
      mstall <= 0;
      mflush <= 0;
    end else begin
      if (m_lu() && !bus.Redirect_E && mstall < 65535) mstall <= mstall + 1;
      if (bus.Redirect_E && mflush < 65535) mflush <= mflush + 1;
      p[2] <= p[1];
      p[1] <= p[0];
      if (bus.Redirect_E || m_lu()) p[0] <= '{default: 0};
      else p[0] <= '{v: 1, rw: bus.RegWrite_D, mr: bus.MemRead_D, d: int'(bus.DestReg_D),
                     rs: bus.UsesRs_D ? int'(bus.Rs_D) : 0, rt: bus.UsesRt_D ? int'(bus.Rt_D) : 0};
    end
  end
  always @(posedge clk) begin
    #2;
    chk("stall_f", 32'(bus.Stall_F), 32'(m_lu() && !bus.Redirect_E));
    chk("stall_d", 32'(bus.Stall_D), 32'(m_lu() && !bus.Redirect_E));
    chk("flush_d", 32'(bus.Flush_D), 32'(bus.Redirect_E));
    chk("flush_e", 32'(bus.Flush_E), 32'(bus.Redirect_E || m_lu()));
    chk("fwd_a", 32'(bus.ForwardA_E), 32'(m_fwd(p[0].rs)));
    chk("fwd_b", 32'(bus.ForwardB_E), 32'(m_fwd(p[0].rt)));
    chk("stall_cnt", 32'(bus.StallCount), 32'(mstall));
    chk("flush_cnt", 32'(bus.FlushCount), 32'(mflush));
  end
  task automatic step(input int rs, input int rt, input bit ur, input bit ut,
                      input int dst, input bit rw, input bit mr, input bit redir);
    @(posedge clk);
    bus.Rs_D = 5'(rs);
    bus.Rt_D = 5'(rt);
    bus.UsesRs_D = ur;
    bus.UsesRt_D = ut;
    bus.DestReg_D = 5'(dst);
    bus.RegWrite_D = rw;
    bus.MemRead_D = mr;
    bus.Redirect_E = redir;
    #3;
  endtask
  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    step(8, 8, 1, 1, 8, 1, 1, 0);
    step(8, 8, 1, 1, 8, 1, 1, 0);
    chk("rst_stall", 32'(bus.Stall_F), 0);
    chk("rst_flush", 32'({bus.Flush_D, bus.Flush_E}), 0);
    chk("rst_fwd", 32'({bus.ForwardA_E, bus.ForwardB_E}), 0);
    chk("rst_cnt", 32'({bus.StallCount, bus.FlushCount}), 0);
    @(posedge clk);
    reset = 1'b1;
    // lw $8 then add $9,$8,$10
    step(29, 0, 1, 0, 8, 1, 1, 0);
    step(8, 10, 1, 1, 9, 1, 0, 0);
    chk("lu_stall_f", 32'(bus.Stall_F), 1);
    chk("lu_flush_e", 32'(bus.Flush_E), 1);
    chk("lu_flush_d", 32'(bus.Flush_D), 0);
    step(8, 10, 1, 1, 9, 1, 0, 0);
    chk("lu_one_cycle", 32'(bus.Stall_F), 0);
    nop();
    chk("lu_fwd_a", 32'(bus.ForwardA_E), 32'b01);
    chk("lu_count", 32'(bus.StallCount), 1);
    // add $3,$1,$2 then sub $4,$3,$3
    step(1, 2, 1, 1, 3, 1, 0, 0);
    step(3, 3, 1, 1, 4, 1, 0, 0);
    chk("alu_no_stall", 32'(bus.Stall_F), 0);
    nop();
    chk("alu_fwd_a", 32'(bus.ForwardA_E), 32'b10);
    chk("alu_fwd_b", 32'(bus.ForwardB_E), 32'b10);
    // add $5 ; or $5 ; and $6,$5,$0
    step(1, 2, 1, 1, 5, 1, 0, 0);
    step(1, 2, 1, 1, 5, 1, 0, 0);
    step(5, 0, 1, 1, 6, 1, 0, 0);
    nop();
    chk("prio_fwd_a", 32'(bus.ForwardA_E), 32'b10);
    chk("prio_fwd_b", 32'(bus.ForwardB_E), 32'b00);
    // lw $8 in E, consumer in D, redirect on the same cycle
    step(29, 0, 1, 0, 8, 1, 1, 0);
    step(8, 10, 1, 1, 9, 1, 0, 1);
    chk("redir_flush", 32'({bus.Flush_D, bus.Flush_E}), 32'b11);
    chk("redir_stall", 32'({bus.Stall_F, bus.Stall_D}), 0);
    nop();
    chk("redir_scnt", 32'(bus.StallCount), 1);
    chk("redir_fcnt", 32'(bus.FlushCount), 1);
    chk("redir_bubble", 32'({bus.ForwardA_E, bus.ForwardB_E}), 0);
    // lw $0 then a consumer of $0
    step(29, 0, 1, 0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 7, 1, 0, 0);
    chk("r0_no_stall", 32'(bus.Stall_F), 0);
    nop();
    chk("r0_fwd_m", 32'({bus.ForwardA_E, bus.ForwardB_E}), 0);
    nop();
    chk("r0_fwd_w", 32'({bus.ForwardA_E, bus.ForwardB_E}), 0);
    // saturation, then reset in the middle of a stall
    dut.sc_q = 16'hFFFF;
    mstall = 65535;
    step(29, 0, 1, 0, 8, 1, 1, 0);
    step(0, 8, 0, 1, 9, 1, 0, 0);
    chk("sat_stall", 32'(bus.Stall_F), 1);
    nop();
    chk("sat_hold", 32'(bus.StallCount), 32'hFFFF);
    step(29, 0, 1, 0, 8, 1, 1, 0);
    step(8, 0, 1, 0, 9, 1, 0, 0);
    chk("sat_stall2", 32'(bus.Stall_F), 1);
    reset = 1'b0;
    #1;
    chk("async_stall", 32'({bus.Stall_F, bus.Stall_D, bus.Flush_E, bus.Flush_D}), 0);
    chk("async_cnt", 32'({bus.StallCount, bus.FlushCount}), 0);
    chk("async_fwd", 32'({bus.ForwardA_E, bus.ForwardB_E}), 0);
    @(posedge clk);
    reset = 1'b1;
    step(29, 0, 1, 0, 8, 1, 1, 0);
    step(8, 0, 1, 0, 9, 1, 0, 0);
    chk("post_rst_load", 32'(bus.Stall_F), 1);
    nop();
    nop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
